// File: rtl/fetch_stage_if.sv
// Handshake bundle between the fetch stage, instruction memory and decode.
// The master side is the fetch stage; the slave side is the memory/decode
// environment.
interface fetch_stage_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INSN_WIDTH = 32
);
  // Instruction-memory request/response channel.
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-3:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [INSN_WIDTH-1:0] imem_rsp_data;

  // Decode channel.
  logic                  insn_valid;
  logic                  insn_ready;
  logic [INSN_WIDTH-1:0] insn_data;
  logic [ADDR_WIDTH-3:0] insn_pc;

  modport master (
    output imem_req_valid, imem_req_addr, insn_valid, insn_data, insn_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, insn_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, insn_valid, insn_data, insn_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, insn_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: issues sequential word-address requests to instruction memory,
// buffers in-order responses in a DEPTH-entry circular buffer, and hands
// instruction/PC pairs to decode. Credits (buffer entries plus responses still
// owed to a flushed stream) bound the number of requests in flight.

// Protocol checker: every response must match an outstanding request, and the
// credit total may never exceed the buffer depth.
module fetch_stage_checker #(
  parameter int CNT_W = 3,
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  input logic             rsp_valid,
  input logic [CNT_W-1:0] count,
  input logic [CNT_W-1:0] pend_cnt,
  input logic [CNT_W-1:0] drop_cnt
);
  rsp_has_owner: assert property (@(posedge clk) disable iff (!rst)
    rsp_valid |-> ((pend_cnt != CNT_W'(1'b0)) || (drop_cnt != CNT_W'(1'b0))));

  credit_bound: assert property (@(posedge clk) disable iff (!rst)
    (({1'b0, count} + {1'b0, drop_cnt}) <= (CNT_W+1)'(DEPTH)));
endmodule

module fetch_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int INSN_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-3:0] rst_addr,
  input  logic                  backend_redirect_en,
  input  logic [ADDR_WIDTH-3:0] backend_redirect_addr,
  output logic [ADDR_WIDTH-3:0] fetch_addr,
  fetch_stage_if.master         bus
);
  localparam int WA    = ADDR_WIDTH - 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE      = PTR_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ZERO     = PTR_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(1'b0);
  localparam logic [CNT_W:0]   CREDIT_LIMIT = (CNT_W+1)'(DEPTH);
  localparam logic [WA-1:0]    PC_ONE       = WA'(1'b1);

  // Architectural state.
  logic [WA-1:0]         pc_r;
  logic [WA-1:0]         pc_mem_r   [DEPTH];
  logic [INSN_WIDTH-1:0] insn_mem_r [DEPTH];
  logic [DEPTH-1:0]      filled_r;
  logic [PTR_W-1:0]      alloc_ptr_r;
  logic [PTR_W-1:0]      fill_ptr_r;
  logic [PTR_W-1:0]      head_ptr_r;
  logic [CNT_W-1:0]      count_r;     // allocated buffer entries
  logic [CNT_W-1:0]      drop_cnt_r;  // responses owed to a flushed stream
  logic [CNT_W-1:0]      pend_cnt_r;  // allocated entries still waiting for data

  // Per-cycle events.
  logic [CNT_W:0]   credit_sum_s;
  logic [CNT_W:0]   outstanding_s;
  logic             req_valid_s;
  logic             req_fire_s;
  logic             rsp_drop_s;
  logic             rsp_fill_s;
  logic             insn_valid_s;
  logic             pop_s;
  logic [CNT_W-1:0] count_next_s;
  logic [CNT_W-1:0] pend_next_s;
  logic [CNT_W-1:0] redirect_drop_s;

  // Handshake qualification; outputs are held low while reset is asserted.
  always_comb begin
    credit_sum_s = {1'b0, count_r} + {1'b0, drop_cnt_r};
    req_valid_s  = rst & (credit_sum_s < CREDIT_LIMIT);
    req_fire_s   = req_valid_s & bus.imem_req_ready;
    rsp_drop_s   = rst & bus.imem_rsp_valid & (drop_cnt_r != CNT_ZERO);
    rsp_fill_s   = rst & bus.imem_rsp_valid & (drop_cnt_r == CNT_ZERO);
    insn_valid_s = rst & filled_r[head_ptr_r] & (count_r != CNT_ZERO);
    pop_s        = insn_valid_s & bus.insn_ready;
  end

  // Next values of the occupancy counters and of the drop count on a flush.
  always_comb begin
    count_next_s = count_r;
    pend_next_s  = pend_cnt_r;
    case ({req_fire_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
    case ({req_fire_s, rsp_fill_s})
      2'b10:   pend_next_s = pend_cnt_r + CNT_ONE;
      2'b01:   pend_next_s = pend_cnt_r - CNT_ONE;
      default: pend_next_s = pend_cnt_r;
    endcase
    // Everything still owed by memory after this cycle belongs to the old
    // stream, including a request accepted in the redirect cycle itself.
    outstanding_s = {1'b0, pend_cnt_r} + {1'b0, drop_cnt_r}
                  + (CNT_W+1)'(req_fire_s) - (CNT_W+1)'(bus.imem_rsp_valid);
    redirect_drop_s = outstanding_s[CNT_W-1:0];
  end

  // Control state: PC, pointers, counters and per-entry filled flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_r        <= rst_addr;
      alloc_ptr_r <= PTR_ZERO;
      fill_ptr_r  <= PTR_ZERO;
      head_ptr_r  <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      drop_cnt_r  <= CNT_ZERO;
      pend_cnt_r  <= CNT_ZERO;
      filled_r    <= {DEPTH{1'b0}};
    end else if (backend_redirect_en) begin
      pc_r        <= backend_redirect_addr;
      alloc_ptr_r <= PTR_ZERO;
      fill_ptr_r  <= PTR_ZERO;
      head_ptr_r  <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      drop_cnt_r  <= redirect_drop_s;
      pend_cnt_r  <= CNT_ZERO;
      filled_r    <= {DEPTH{1'b0}};
    end else begin
      if (req_fire_s) begin
        alloc_ptr_r           <= alloc_ptr_r + PTR_ONE;
        pc_r                  <= pc_r + PC_ONE;
        filled_r[alloc_ptr_r] <= 1'b0;
      end
      if (rsp_drop_s) begin
        drop_cnt_r <= drop_cnt_r - CNT_ONE;
      end
      if (rsp_fill_s) begin
        fill_ptr_r           <= fill_ptr_r + PTR_ONE;
        filled_r[fill_ptr_r] <= 1'b1;
      end
      if (pop_s) begin
        head_ptr_r           <= head_ptr_r + PTR_ONE;
        filled_r[head_ptr_r] <= 1'b0;
      end
      count_r    <= count_next_s;
      pend_cnt_r <= pend_next_s;
    end
  end

  // Buffer payload; validity is tracked by filled_r so no reset is needed.
  always_ff @(posedge clk) begin
    if (req_fire_s && !backend_redirect_en) begin
      pc_mem_r[alloc_ptr_r] <= pc_r;
    end
    if (rsp_fill_s && !backend_redirect_en) begin
      insn_mem_r[fill_ptr_r] <= bus.imem_rsp_data;
    end
  end

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = pc_r;
  assign bus.insn_valid     = insn_valid_s;
  assign bus.insn_data      = insn_mem_r[head_ptr_r];
  assign bus.insn_pc        = pc_mem_r[head_ptr_r];
  assign fetch_addr         = pc_r;

  fetch_stage_checker #(
    .CNT_W (CNT_W),
    .DEPTH (DEPTH)
  ) u_checker (
    .clk       (clk),
    .rst       (rst),
    .rsp_valid (bus.imem_rsp_valid),
    .count     (count_r),
    .pend_cnt  (pend_cnt_r),
    .drop_cnt  (drop_cnt_r)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model with random latency, random
// back-pressure, redirects and resets. The expected decode stream is a simple
// sequence "start, start+1, ..." restarted at every reset/redirect; a monitor
// pops it on each decode handshake.
module tb_fetch_stage;
  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int WA    = AW - 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [WA-1:0] rst_addr = '0;
  logic          redirect_en = 1'b0;
  logic [WA-1:0] redirect_addr = '0;
  logic [WA-1:0] fetch_addr;

  fetch_stage_if #(.ADDR_WIDTH(AW), .INSN_WIDTH(IW)) bus ();

  fetch_stage #(.ADDR_WIDTH(AW), .INSN_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .rst_addr              (rst_addr),
    .backend_redirect_en   (redirect_en),
    .backend_redirect_addr (redirect_addr),
    .fetch_addr            (fetch_addr),
    .bus                   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [IW-1:0] mem_word(input logic [WA-1:0] a);
    return {a[15:0], a[29:14]} ^ 32'hC3A5_5A3C;
  endfunction

  // ---------------- memory model ----------------
  typedef struct { logic [WA-1:0] addr; int due; } mreq_t;
  mreq_t mem_q[$];
  int    cyc = 0;
  int    lat_min = 1;
  int    lat_max = 1;
  int    acc_cnt = 0;
  bit    rand_ready = 1'b0;

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(mem_q[0].addr);
        void'(mem_q.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
      end
      bus.imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (!rst) begin
        mem_q.delete();
      end else if (bus.imem_req_valid && bus.imem_req_ready) begin
        mem_q.push_back('{bus.imem_req_addr, cyc + int'($urandom_range(lat_min, lat_max))});
        acc_cnt++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [WA-1:0] pc; logic [IW-1:0] data; } exp_t;
  exp_t          exp_q[$];
  logic [WA-1:0] model_pc = '0;
  int            hs_total = 0;

  task automatic top_up();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{model_pc, mem_word(model_pc)});
      model_pc = model_pc + 1'b1;
    end
  endtask

  task automatic restart_stream(input logic [WA-1:0] a);
    exp_q.delete();
    model_pc = a;
    top_up();
  endtask

  // Monitor: compare every decode handshake against the expected stream.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst && bus.insn_valid && bus.insn_ready) begin
        hs_total++;
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("insn_pc", 64'(bus.insn_pc), 64'(e.pc));
          chk("insn_data", 64'(bus.insn_data), 64'(e.data));
        end
      end
      if (bus.imem_req_valid) begin
        chk("req_addr_vs_fetch_addr", 64'(bus.imem_req_addr), 64'(fetch_addr));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    top_up();
  endtask

  // One-cycle reset; called at a negedge, returns at +1 of the first run cycle.
  task automatic reset_one(input logic [WA-1:0] a);
    rst = 1'b0;
    rst_addr = a;
    redirect_en = 1'b0;
    restart_stream(a);
    #1;
    chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("rst_insn_valid", 64'(bus.insn_valid), 64'd0);
    step();
    rst = 1'b1;
    #1;
    chk("post_rst_fetch_addr", 64'(fetch_addr), 64'(a));
    chk("first_req_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("first_req_addr", 64'(bus.imem_req_addr), 64'(a));
  endtask

  // One-cycle redirect pulse; called at a negedge, returns at a negedge.
  task automatic redirect_to(input logic [WA-1:0] a);
    redirect_en = 1'b1;
    redirect_addr = a;
    step();
    redirect_en = 1'b0;
    restart_stream(a);
  endtask

  initial begin
    int            h0;
    int            a0;
    logic [WA-1:0] wrap_start;
    logic [WA-1:0] wrap_next;

    bus.insn_ready = 1'b1;
    step();
    step();

    // Reset and sustained stream from 0x100 with a 1-cycle memory.
    h0 = hs_total;
    reset_one(30'h100);
    chk("stream_c1_insn_valid", 64'(bus.insn_valid), 64'd0);
    for (int k = 2; k <= 12; k++) begin
      step();
      #1;
      chk("stream_insn_valid", 64'(bus.insn_valid), 64'(k >= 3));
    end
    step();
    chk("stream_count", 64'(hs_total - h0), 64'd10);

    // Credit stall: decode never ready, exactly DEPTH requests accepted.
    bus.insn_ready = 1'b0;
    a0 = acc_cnt;
    reset_one(30'h300);
    repeat (12) step();
    chk("credit_accepts", 64'(acc_cnt - a0), 64'(DEPTH));
    #1;
    chk("credit_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("credit_insn_valid", 64'(bus.insn_valid), 64'd1);
    step();
    bus.insn_ready = 1'b1;
    step();
    bus.insn_ready = 1'b0;
    repeat (10) step();
    chk("credit_one_more", 64'(acc_cnt - a0), 64'(DEPTH + 1));

    // Redirect with three requests in flight on a 3-cycle memory.
    step();
    bus.insn_ready = 1'b1;
    lat_min = 3;
    lat_max = 3;
    a0 = acc_cnt;
    reset_one(30'h100);
    step();
    step();
    redirect_en = 1'b1;
    redirect_addr = 30'h200;
    step();
    chk("inflight_at_redirect", 64'(acc_cnt - a0), 64'd3);
    redirect_en = 1'b0;
    restart_stream(30'h200);
    #1;
    chk("redirect_req_addr", 64'(bus.imem_req_addr), 64'h200);
    h0 = hs_total;
    repeat (20) step();
    chk("redirect_delivered", 64'(hs_total - h0 >= 10), 64'd1);

    // Redirect coinciding with a request handshake, a response and a pop.
    lat_min = 1;
    lat_max = 1;
    step();
    reset_one(30'h400);
    repeat (4) step();
    step();
    redirect_en = 1'b1;
    redirect_addr = 30'h280;
    #1;
    chk("sim_req_fire", 64'(bus.imem_req_valid & bus.imem_req_ready), 64'd1);
    chk("sim_rsp_valid", 64'(bus.imem_rsp_valid), 64'd1);
    chk("sim_insn_hs", 64'(bus.insn_valid & bus.insn_ready), 64'd1);
    step();
    redirect_en = 1'b0;
    restart_stream(30'h280);
    h0 = hs_total;
    repeat (15) step();
    chk("sim_delivered", 64'(hs_total - h0 >= 8), 64'd1);

    // PC wrap at the top of the word-address space.
    wrap_start = '1;
    wrap_next  = wrap_start + 1'b1;
    step();
    h0 = hs_total;
    reset_one(wrap_start);
    step();
    #1;
    chk("wrap_fetch_addr", 64'(fetch_addr), 64'(wrap_next));
    repeat (8) step();
    chk("wrap_delivered", 64'(hs_total - h0 >= 4), 64'd1);

    // Mid-stream reset with a full buffer.
    bus.insn_ready = 1'b0;
    repeat (8) step();
    #1;
    chk("full_insn_valid", 64'(bus.insn_valid), 64'd1);
    chk("full_req_valid", 64'(bus.imem_req_valid), 64'd0);
    step();
    reset_one(30'h140);
    step();
    bus.insn_ready = 1'b1;
    h0 = hs_total;
    repeat (10) step();
    chk("midrst_delivered", 64'(hs_total - h0 >= 5), 64'd1);

    // Randomised traffic: latency, back-pressure, redirects, resets.
    rand_ready = 1'b1;
    lat_min = 1;
    lat_max = 5;
    step();
    reset_one(WA'($urandom()));
    for (int i = 0; i < 1500; i++) begin
      step();
      bus.insn_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        redirect_to(WA'($urandom()));
      end else if ($urandom_range(0, 299) == 0) begin
        reset_one(WA'($urandom()));
      end
    end

    // Drain with everything ready.
    step();
    rand_ready = 1'b0;
    bus.insn_ready = 1'b1;
    h0 = hs_total;
    repeat (30) step();
    chk("drain_delivered", 64'(hs_total - h0 >= 10), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its end, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
